// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: assembles SYNC/CMD/LEN/payload/CSUM frames from the UART
// receiver byte stream and presents validated packets on a one-deep
// valid/ready output register. Dropped frames raise a one-cycle error pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data/rx_valid      received byte and its one-cycle strobe
//   rx_frame_err          one-cycle UART framing-error strobe
//   pkt_valid/pkt_ready   output packet handshake
//   pkt_cmd/pkt_len       command byte and payload length of the held packet
//   pkt_payload           payload, byte i at [8i+7:8i], unused bytes read 0
//   err_csum/err_len/err_timeout/err_frame/err_overrun   one-cycle drop pulses
//   pkt_count             packets loaded into the output register (wraps)
module uart_pkt_parser #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned MAX_LEN      = 8,
    parameter int unsigned TIMEOUT_CLKS = 4800
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_valid,
    input  logic                             rx_frame_err,
    output logic                             pkt_valid,
    input  logic                             pkt_ready,
    output logic [7:0]                       pkt_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0]     pkt_len,
    output logic [8*MAX_LEN-1:0]             pkt_payload,
    output logic                             err_csum,
    output logic                             err_len,
    output logic                             err_timeout,
    output logic                             err_frame,
    output logic                             err_overrun,
    output logic [15:0]                      pkt_count
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned PAY_W = 8 * MAX_LEN;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAY,
        S_CSUM
    } state_t;

    state_t             state;
    state_t             state_nxt;

    // Working registers, independent of the output register
    logic [7:0]         cmd_q;
    logic [LEN_W-1:0]   len_q;
    logic [PAY_W-1:0]   pay_q;
    logic [7:0]         sum_q;
    logic [LEN_W-1:0]   idx_q;
    logic [TMO_W-1:0]   tmo_cnt;

    logic               abort_c;
    logic               accept_c;
    logic               out_free_c;
    logic               load_c;
    logic               csum_bad_c;
    logic               len_bad_c;
    logic               tmo_hit_c;
    logic               overrun_c;

    // A framing error inside a frame outranks any byte arriving with it
    assign abort_c    = rx_frame_err && (state != S_IDLE);
    assign accept_c   = rx_valid && !abort_c;
    assign out_free_c = !pkt_valid || pkt_ready;

    // Next-state and event decode
    always_comb begin
        state_nxt  = state;
        load_c     = 1'b0;
        csum_bad_c = 1'b0;
        len_bad_c  = 1'b0;
        tmo_hit_c  = 1'b0;
        overrun_c  = 1'b0;
        if (abort_c) begin
            state_nxt = S_IDLE;
        end else if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) state_nxt = S_CMD;
                end
                S_CMD: state_nxt = S_LEN;
                S_LEN: begin
                    if (rx_data > 8'(MAX_LEN)) begin
                        len_bad_c = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (rx_data == 8'd0) begin
                        state_nxt = S_CSUM;
                    end else begin
                        state_nxt = S_PAY;
                    end
                end
                S_PAY: begin
                    if (idx_q == len_q - LEN_W'(1)) state_nxt = S_CSUM;
                end
                S_CSUM: begin
                    state_nxt = S_IDLE;
                    if (rx_data != sum_q)  csum_bad_c = 1'b1;
                    else if (out_free_c)   load_c     = 1'b1;
                    else                   overrun_c  = 1'b1;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (state != S_IDLE && tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1)) begin
            tmo_hit_c = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Inter-byte timeout counter; idle state always sees it at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               tmo_cnt <= '0;
        else if (rx_valid || state_nxt == S_IDLE) tmo_cnt <= '0;
        else                                      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    // Working buffer and running checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
            len_q <= '0;
            pay_q <= '0;
            sum_q <= '0;
            idx_q <= '0;
        end else if (accept_c) begin
            case (state)
                S_CMD: begin
                    cmd_q <= rx_data;
                    sum_q <= rx_data;
                end
                S_LEN: begin
                    if (!len_bad_c) begin
                        len_q <= LEN_W'(rx_data);
                        sum_q <= sum_q + rx_data;
                        pay_q <= '0;
                        idx_q <= '0;
                    end
                end
                S_PAY: begin
                    for (int i = 0; i < int'(MAX_LEN); i++) begin
                        if (idx_q == LEN_W'(i)) pay_q[8*i +: 8] <= rx_data;
                    end
                    sum_q <= sum_q + rx_data;
                    idx_q <= idx_q + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Output register, handshake and packet counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_valid   <= 1'b0;
            pkt_cmd     <= '0;
            pkt_len     <= '0;
            pkt_payload <= '0;
            pkt_count   <= '0;
        end else if (load_c) begin
            pkt_valid   <= 1'b1;
            pkt_cmd     <= cmd_q;
            pkt_len     <= len_q;
            pkt_payload <= pay_q;
            pkt_count   <= pkt_count + 16'd1;
        end else if (pkt_valid && pkt_ready) begin
            pkt_valid   <= 1'b0;
        end
    end

    // Error pulses, one cycle each
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_csum    <= csum_bad_c;
            err_len     <= len_bad_c;
            err_timeout <= tmo_hit_c;
            err_frame   <= abort_c;
            err_overrun <= overrun_c;
        end
    end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Bench for uart_pkt_parser: directed frames, a queue-based reference model
// checked against the DUT every cycle, and literal expectations.
module tb_uart_pkt_parser;

    localparam int unsigned MAX_LEN  = 8;
    localparam int unsigned TMO      = 4800;
    localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1);
    localparam int unsigned PAY_W    = 8 * MAX_LEN;
    localparam logic [7:0]  SYNC     = 8'hA5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_frame_err;
    logic               pkt_ready;
    logic               pkt_valid;
    logic [7:0]         pkt_cmd;
    logic [LEN_W-1:0]   pkt_len;
    logic [PAY_W-1:0]   pkt_payload;
    logic               err_csum, err_len, err_timeout, err_frame, err_overrun;
    logic [15:0]        pkt_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    uart_pkt_parser #(
        .SYNC_BYTE   (SYNC),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_cmd     (pkt_cmd),
        .pkt_len     (pkt_len),
        .pkt_payload (pkt_payload),
        .err_csum    (err_csum),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic               m_in;
    logic [7:0]         q[$];
    int                 m_gap;
    logic               m_valid;
    logic [7:0]         m_cmd;
    logic [LEN_W-1:0]   m_len;
    logic [PAY_W-1:0]   m_pay;
    logic [15:0]        m_count;
    logic [4:0]         m_err;  // {csum, len, timeout, frame, overrun}

    task automatic model_reset();
        m_in = 1'b0; q.delete(); m_gap = 0;
        m_valid = 1'b0; m_cmd = '0; m_len = '0; m_pay = '0;
        m_count = '0; m_err = '0;
    endtask

    // One clock of the frame rules, applied to the inputs present at the edge
    task automatic model_step();
        int sum;
        logic free;
        free  = !m_valid || pkt_ready;
        m_err = '0;
        if (m_valid && pkt_ready) m_valid = 1'b0;
        if (m_in && rx_frame_err) begin
            m_err[1] = 1'b1;
            m_in = 1'b0;
        end else if (rx_valid) begin
            if (!m_in) begin
                if (rx_data == SYNC) begin
                    m_in = 1'b1; q.delete(); m_gap = 0;
                end
            end else begin
                q.push_back(rx_data);
                m_gap = 0;
                if (q.size() == 2 && int'(q[1]) > int'(MAX_LEN)) begin
                    m_err[3] = 1'b1;
                    m_in = 1'b0;
                end else if (q.size() >= 2 && q.size() == int'(q[1]) + 3) begin
                    m_in = 1'b0;
                    sum = 0;
                    for (int i = 0; i < q.size() - 1; i++) sum += int'(q[i]);
                    if ((sum % 256) != int'(rx_data)) begin
                        m_err[4] = 1'b1;
                    end else if (free) begin
                        m_valid = 1'b1;
                        m_cmd   = q[0];
                        m_len   = LEN_W'(q[1]);
                        m_pay   = '0;
                        for (int i = 0; i < int'(q[1]); i++) m_pay[8*i +: 8] = q[2+i];
                        m_count = m_count + 16'd1;
                    end else begin
                        m_err[0] = 1'b1;
                    end
                end
            end
        end else if (m_in) begin
            m_gap++;
            if (m_gap == int'(TMO)) begin
                m_err[2] = 1'b1;
                m_in = 1'b0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc pkt_valid", 64'(pkt_valid), 64'(m_valid));
            chk("cyc pkt_cmd", 64'(pkt_cmd), 64'(m_cmd));
            chk("cyc pkt_len", 64'(pkt_len), 64'(m_len));
            chk("cyc pkt_payload", 64'(pkt_payload), 64'(m_pay));
            chk("cyc pkt_count", 64'(pkt_count), 64'(m_count));
            chk("cyc errors", 64'({err_csum, err_len, err_timeout, err_frame, err_overrun}),
                64'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    // Every task starts and ends 1 time unit after a rising edge
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] f[], input int gap);
        foreach (f[i]) begin
            send(f[i]);
            if (gap > 0 && i != f.size() - 1) idle(gap);
        end
    endtask

    task automatic chk_errs(input string name, input logic [4:0] exp);
        chk(name, 64'({err_csum, err_len, err_timeout, err_frame, err_overrun}), 64'(exp));
    endtask

    initial begin
        logic [7:0] good[] = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_frame_err = 1'b0; pkt_ready = 1'b1;
        model_reset();
        idle(3);
        chk("reset pkt_valid", 64'(pkt_valid), 64'd0);
        chk("reset pkt_count", 64'(pkt_count), 64'd0);
        chk("reset payload", 64'(pkt_payload), 64'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        idle(2);

        // Good frame with consumer ready
        send_frame(good, 0);
        chk("good valid", 64'(pkt_valid), 64'd1);
        chk("good cmd", 64'(pkt_cmd), 64'h10);
        chk("good len", 64'(pkt_len), 64'd3);
        chk("good payload", 64'(pkt_payload), 64'h0000_0000_0003_0201);
        chk("good count", 64'(pkt_count), 64'd1);
        idle(1);
        chk("good valid drops", 64'(pkt_valid), 64'd0);

        // Zero-length frame
        send_frame('{8'hA5, 8'h22, 8'h00, 8'h22}, 0);
        chk("zlen valid", 64'(pkt_valid), 64'd1);
        chk("zlen len", 64'(pkt_len), 64'd0);
        chk("zlen payload", 64'(pkt_payload), 64'd0);
        chk("zlen count", 64'(pkt_count), 64'd2);
        idle(2);

        // Checksum error
        send_frame('{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18}, 0);
        chk_errs("csum pulse", 5'b10000);
        chk("csum no valid", 64'(pkt_valid), 64'd0);
        idle(1);
        chk_errs("csum pulse ends", 5'b00000);

        // Oversized length, then a good frame
        send_frame('{8'hA5, 8'h10, 8'h09}, 0);
        chk_errs("len pulse", 5'b01000);
        send_frame(good, 0);
        chk("after len valid", 64'(pkt_valid), 64'd1);
        chk("after len count", 64'(pkt_count), 64'd3);
        idle(2);

        // Back-pressure and overrun
        pkt_ready = 1'b0;
        send_frame('{8'hA5, 8'h31, 8'h01, 8'h7F, 8'hB1}, 0);
        chk("bp first cmd", 64'(pkt_cmd), 64'h31);
        idle(5);
        chk("bp held valid", 64'(pkt_valid), 64'd1);
        chk("bp held payload", 64'(pkt_payload), 64'h7F);
        send_frame(good, 0);
        chk_errs("overrun pulse", 5'b00001);
        chk("overrun cmd kept", 64'(pkt_cmd), 64'h31);
        chk("overrun count", 64'(pkt_count), 64'd4);
        send_frame('{8'hA5, 8'h44, 8'h02, 8'hAA, 8'h55}, 0);
        pkt_ready = 1'b1;
        send(8'h45);
        chk("swap valid", 64'(pkt_valid), 64'd1);
        chk("swap cmd", 64'(pkt_cmd), 64'h44);
        chk("swap payload", 64'(pkt_payload), 64'h55AA);
        chk("swap count", 64'(pkt_count), 64'd5);
        idle(1);
        chk("swap drained", 64'(pkt_valid), 64'd0);

        // Sync value inside a frame is data
        send_frame('{8'hA5, 8'h10, 8'h02, 8'hA5, 8'hA5, 8'h5C}, 0);
        chk("resync payload", 64'(pkt_payload), 64'hA5A5);
        chk("resync count", 64'(pkt_count), 64'd6);

        // Timeout after TMO idle clocks
        send_frame('{8'hA5, 8'h10}, 0);
        idle(int'(TMO) - 1);
        chk_errs("tmo not yet", 5'b00000);
        idle(1);
        chk_errs("tmo pulse", 5'b00100);
        idle(1);
        chk_errs("tmo pulse ends", 5'b00000);
        // Gaps just short of the limit
        send_frame(good, int'(TMO) - 2);
        chk("gap valid", 64'(pkt_valid), 64'd1);
        chk("gap count", 64'(pkt_count), 64'd7);
        idle(2);

        // Frame error in idle is ignored; inside payload it aborts
        rx_frame_err = 1'b1; idle(1); rx_frame_err = 1'b0;
        chk_errs("idle ferr ignored", 5'b00000);
        send_frame('{8'hA5, 8'h10, 8'h03, 8'h01}, 0);
        rx_frame_err = 1'b1; send(8'h02); rx_frame_err = 1'b0;
        chk_errs("frame pulse", 5'b00010);
        send_frame('{8'h03, 8'h19}, 0);
        chk("ferr tail dropped", 64'(pkt_count), 64'd7);
        send_frame(good, 0);
        chk("ferr recover count", 64'(pkt_count), 64'd8);
        idle(2);

        // Reset mid-handshake and mid-payload
        pkt_ready = 1'b0;
        send_frame(good, 0);
        send_frame('{8'hA5, 8'h10, 8'h03, 8'h01}, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst valid", 64'(pkt_valid), 64'd0);
        chk("rst count", 64'(pkt_count), 64'd0);
        chk("rst cmd", 64'(pkt_cmd), 64'd0);
        idle(2);
        rst_n = 1'b1;
        pkt_ready = 1'b1;
        idle(1);
        send_frame(good, 0);
        chk("post rst valid", 64'(pkt_valid), 64'd1);
        chk("post rst payload", 64'(pkt_payload), 64'h0003_0201);
        chk("post rst count", 64'(pkt_count), 64'd1);
        idle(3);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_pkt_parser.md
Name: uart_pkt_parser

Overview:
- Consumes the byte stream from the 3 Mbaud UART receiver (rx_data/rx_valid/rx_frame_err) and assembles framed command packets for the bridge command logic.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CSUM. CSUM is the 8-bit sum, modulo 256, of CMD, LEN and all payload bytes.
- Validated packets are presented on a one-deep valid/ready output register. Malformed, timed-out and overrun packets are dropped, and each drop raises a one-cycle error pulse.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 8, maximum payload bytes (1..16).
- TIMEOUT_CLKS, 4800, maximum idle clocks between bytes inside a frame (100 us at 48 MHz).

Ports:
- clk  in  1  system clock, 48 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- rx_frame_err  in  1  one-cycle UART framing-error strobe.
- pkt_valid  out  1  output packet held and valid.
- pkt_ready  in  1  consumer accepts the packet when pkt_valid && pkt_ready.
- pkt_cmd  out  8  command byte.
- pkt_len  out  $clog2(MAX_LEN+1)  payload length.
- pkt_payload  out  8*MAX_LEN  payload; byte i sits at [8i+7:8i]; bytes at i >= pkt_len read as 0.
- err_csum  out  1  pulse: checksum mismatch.
- err_len  out  1  pulse: LEN > MAX_LEN.
- err_timeout  out  1  pulse: inter-byte timeout inside a frame.
- err_frame  out  1  pulse: rx_frame_err seen while inside a frame.
- err_overrun  out  1  pulse: a good packet completed while the output register was full.
- pkt_count  out  16  count of packets loaded into the output register; wraps at 16'hFFFF.

Behaviour:
- Reset: clk and rst_n are the clock and the asynchronous active-low reset. All outputs, pkt_count and all error pulses reset to 0; state resets to S_IDLE; the working buffer and checksum reset to 0.
- Working registers: cmd, len, payload, running sum, byte index, timeout counter. These are separate from the output registers, so parsing continues while pkt_valid is held.
- S_IDLE:
  - On rx_valid with rx_data == SYNC_BYTE, go to S_CMD.
  - Other bytes are ignored.
  - rx_frame_err is ignored here and raises no err_frame.
- S_CMD:
  - On rx_valid, latch cmd, set sum = rx_data, go to S_LEN.
- S_LEN:
  - On rx_valid, if rx_data > MAX_LEN: pulse err_len and go to S_IDLE.
  - Otherwise latch len, sum += rx_data, clear the working payload and index.
  - Go to S_PAY if len != 0, else go to S_CSUM.
- S_PAY:
  - On rx_valid, store the byte at the current index, sum += rx_data, increment the index.
  - Go to S_CSUM after byte len-1.
- S_CSUM:
  - On rx_valid, return to S_IDLE.
  - If rx_data != sum (8-bit), pulse err_csum.
  - Else if the output is free (!pkt_valid || pkt_ready in this cycle): load pkt_cmd, pkt_len and pkt_payload, set pkt_valid, and increment pkt_count.
  - Else pulse err_overrun and drop the packet.
- Latency: pkt_valid rises on the clock edge following the rx_valid that carries CSUM, i.e. exactly 1 cycle.
- Output handshake:
  - pkt_valid clears on pkt_valid && pkt_ready, unless a new packet loads in the same cycle; in that case it stays 1 with the new contents.
  - Outputs are stable while pkt_valid && !pkt_ready.
- Timeout:
  - The counter clears on every rx_valid and while in S_IDLE.
  - In any other state, it increments each cycle without rx_valid.
  - On reaching TIMEOUT_CLKS-1: pulse err_timeout and go to S_IDLE.
- Frame error: rx_frame_err in any state other than S_IDLE pulses err_frame and goes to S_IDLE. If rx_valid occurs in the same cycle, the frame error takes priority.
- Resync: a SYNC_BYTE value inside a frame is treated as data; it does not restart the frame.
- Error pulses are mutually exclusive and each lasts 1 cycle.
- Reset mid-frame or mid-handshake discards everything immediately.

Test Plan:
- Good frame: A5 10 03 01 02 03 19 with pkt_ready=1 -> pkt_valid for 1 cycle, 1 cycle after the last rx_valid; pkt_cmd=10, pkt_len=3, pkt_payload[23:0]=030201, upper bytes 0; pkt_count=1.
- Zero length: A5 22 00 22 -> pkt_valid, pkt_len=0, pkt_payload=0.
- Errors:
  - A5 10 03 01 02 03 18 -> err_csum pulse, no pkt_valid.
  - A5 10 09 -> err_len pulse, state S_IDLE; a following good frame is accepted.
- Overrun and back-pressure: hold pkt_ready=0 and send two good frames -> first packet held stable; second raises err_overrun; pkt_count=1. Then raise pkt_ready in the same cycle a third frame's CSUM arrives -> pkt_valid stays 1 with the third packet's contents; pkt_count=2.
- Timeout: send A5 10, then idle 4800 clocks -> err_timeout pulse exactly at count TIMEOUT_CLKS-1. Repeat with gaps of 4798 clocks -> no error.
- Abort and reset: rx_frame_err during S_PAY -> err_frame, back to S_IDLE. Assert rst_n=0 mid-payload -> all outputs 0; the next full frame parses correctly.
